// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: memory access size codes shared with the control decoder, LSU state encodings, size-mask helper
package load_store_unit_pkg;
  localparam logic [1:0] MEM_BS_NONE = 2'b00;
  localparam logic [1:0] MEM_BS_BYTE = 2'b01;
  localparam logic [1:0] MEM_BS_HALF = 2'b10;
  localparam logic [1:0] MEM_BS_WORD = 2'b11;
  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ0,
    LSU_WAIT0,
    LSU_REQ1,
    LSU_WAIT1,
    LSU_RESP
  } lsu_state_t;
  function automatic logic [3:0] bs_mask(input logic [1:0] bs);
    return bs == MEM_BS_WORD ? 4'b1111 : bs == MEM_BS_HALF ? 4'b0011 : bs == MEM_BS_BYTE ? 4'b0001 : 4'b0000;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane steering for stores and read assembly/extension for loads
// ports: off/bs select offset and size; wdata right-aligned store data; rdata0/rdata1 captured beats;
//        be0/be1 and wdata0/wdata1 per-beat lanes; split when the access crosses a word; rdata extended load
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  bs,
  input  logic        se,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic        split,
  output logic [31:0] rdata
);
  logic [3:0]  m;
  logic [5:0]  sh;
  logic [7:0]  mask8;
  logic [31:0] wmask;
  logic [63:0] data64;
  logic [31:0] rd;
  always_comb begin
    m = bs_mask(bs);
    sh = {off, 3'b000};
    mask8 = {4'b0000, m} << off;
    wmask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    data64 = {32'b0, wdata & wmask} << sh;
    {be1, be0} = mask8;
    {wdata1, wdata0} = data64;
    split = |mask8[7:4];
    // low 32 bits of {rdata1,rdata0} >> sh; a 32-bit shift by 32 yields zero, covering off=0
    rd = (rdata0 >> sh) | (rdata1 << (6'd32 - sh));
    rdata = bs == MEM_BS_BYTE ? {{24{se & rd[7]}}, rd[7:0]} :
            bs == MEM_BS_HALF ? {{16{se & rd[15]}}, rd[15:0]} : rd;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store responder driving a word bus, splitting word-crossing accesses
// ports: req_* core request (ready only in IDLE); resp_* one-cycle completion with extended data/error;
//        bus_* beat request held until bus_gnt, read data returned on bus_rvalid
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_se,
  input  logic [1:0]  req_bs,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  lsu_state_t  state;
  logic        we_q, se_q, err_q;
  logic [1:0]  bs_q;
  logic [31:0] addr_q, wdata_q, rd0_q, rd1_q;
  logic        idle, split, bad;
  logic [1:0]  a_off, a_bs;
  logic [3:0]  be0, be1;
  logic [31:0] wd0, wd1, rdata, base;
  // in IDLE the aligner looks at the incoming request so a bad access is rejected on acceptance
  lsu_lane_align u_align (
    .off(a_off), .bs(a_bs), .se(se_q), .wdata(wdata_q), .rdata0(rd0_q), .rdata1(rd1_q),
    .be0(be0), .be1(be1), .wdata0(wd0), .wdata1(wd1), .split(split), .rdata(rdata)
  );
  always_comb begin
    idle = state == LSU_IDLE;
    a_off = idle ? req_addr[1:0] : addr_q[1:0];
    a_bs = idle ? req_bs : bs_q;
    bad = a_bs == MEM_BS_NONE || (split && !ALLOW_MISALIGNED);
    base = {addr_q[31:2], 2'b00};
    req_ready = idle;
    bus_req = state == LSU_REQ0 || state == LSU_REQ1;
    bus_we = bus_req & we_q;
    bus_addr = state == LSU_REQ0 ? base : state == LSU_REQ1 ? base + 32'd4 : 32'd0;
    bus_be = state == LSU_REQ0 ? be0 : state == LSU_REQ1 ? be1 : 4'b0000;
    bus_wdata = !bus_we ? 32'd0 : state == LSU_REQ0 ? wd0 : wd1;
    resp_valid = state == LSU_RESP;
    resp_err = resp_valid & err_q;
    resp_rdata = resp_valid && !err_q && !we_q ? rdata : 32'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LSU_IDLE;
      we_q <= 1'b0;
      se_q <= 1'b0;
      err_q <= 1'b0;
      bs_q <= MEM_BS_NONE;
      addr_q <= '0;
      wdata_q <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      case (state)
        LSU_IDLE: if (req_valid) begin
          we_q <= req_we;
          se_q <= req_se;
          bs_q <= req_bs;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          err_q <= bad;
          state <= bad ? LSU_RESP : LSU_REQ0;
        end
        LSU_REQ0: if (bus_gnt) state <= !we_q ? LSU_WAIT0 : split ? LSU_REQ1 : LSU_RESP;
        LSU_WAIT0: if (bus_rvalid) begin
          rd0_q <= bus_rdata;
          state <= split ? LSU_REQ1 : LSU_RESP;
        end
        LSU_REQ1: if (bus_gnt) state <= we_q ? LSU_RESP : LSU_WAIT1;
        LSU_WAIT1: if (bus_rvalid) begin
          rd1_q <= bus_rdata;
          state <= LSU_RESP;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a reactive bus model for the load/store unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic        req_valid = 0, req_valid0 = 0, req_we = 0, req_se = 0;
  logic [1:0]  req_bs = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        bus_gnt = 0, bus_rvalid = 0, zero = 0;
  logic [31:0] bus_rdata = 0, zero32 = 0;
  logic        req_ready, resp_valid, resp_err, bus_req, bus_we;
  logic [31:0] resp_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        req_ready0, resp_valid0, resp_err0, bus_req0, bus_we0;
  logic [31:0] resp_rdata0, bus_addr0, bus_wdata0;
  logic [3:0]  bus_be0;
  load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_se(req_se), .req_bs(req_bs), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );
  load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .req_se(req_se), .req_bs(req_bs), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0), .bus_req(bus_req0),
    .bus_gnt(zero), .bus_we(bus_we0), .bus_addr(bus_addr0), .bus_be(bus_be0), .bus_wdata(bus_wdata0),
    .bus_rvalid(zero), .bus_rdata(zero32)
  );
  int pass = 0, total = 0;
  exp_t expq[$], exp0[$], me, me0;
  logic [68:0] bq[$], snap, cur;
  logic [31:0] rq[$];
  int gnt_dly = 0, rv_dly = 1, wcnt = -1, rvc = 0;
  bit unstable = 0, bus0_seen = 0;
  task automatic check(input string n, input logic [68:0] a, input logic [68:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask
  // bus model: grants after gnt_dly idle cycles, returns read data rv_dly cycles after grant
  initial forever begin
    @(negedge clk);
    bus_gnt = 0;
    bus_rvalid = 0;
    if (rvc > 0) begin
      rvc--;
      if (rvc == 0) begin
        bus_rvalid = 1;
        bus_rdata = rq.size() > 0 ? rq.pop_front() : 32'hBAD0BAD0;
      end
    end
    cur = {bus_we, bus_addr, bus_be, bus_wdata};
    if (!rst_n) wcnt = -1;
    else if (bus_req) begin
      if (wcnt < 0) begin
        snap = cur;
        wcnt = gnt_dly;
      end else if (cur !== snap) unstable = 1;
      if (wcnt == 0) begin
        if (bq.size() == 0) check("unexpected_beat", 1, 0);
        else check("beat", snap, bq.pop_front());
        bus_gnt = 1;
        if (!bus_we) rvc = rv_dly;
        wcnt = -1;
      end else wcnt--;
    end
  end
  always @(negedge clk) begin
    if (resp_valid) begin
      if (expq.size() == 0) check("unexpected_resp", 1, 0);
      else begin
        me = expq.pop_front();
        check("resp_rdata", resp_rdata, me.rdata);
        check("resp_err", resp_err, me.err);
        check("latency", cyc - me.t0, me.lat);
        check("ready_in_resp", req_ready, 0);
      end
    end
    if (bus_req0 | bus_we0 | (|bus_be0) | (|bus_addr0) | (|bus_wdata0)) bus0_seen = 1;
    if (resp_valid0) begin
      if (exp0.size() == 0) check("unexpected_resp0", 1, 0);
      else begin
        me0 = exp0.pop_front();
        check("resp_rdata0", resp_rdata0, me0.rdata);
        check("resp_err0", resp_err0, me0.err);
        check("latency0", cyc - me0.t0, me0.lat);
      end
    end
  end
  task automatic issue(input bit d0, input bit we, input bit se, input logic [1:0] bs,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] er,
                       input bit ee, input int lat, input bit chk = 1);
    exp_t e;
    for (int i = 0; i < 50 && !(d0 ? req_ready0 : req_ready); i++) @(negedge clk);
    if (!(d0 ? req_ready0 : req_ready)) check("ready_timeout", 0, 1);
    req_we = we;
    req_se = se;
    req_bs = bs;
    req_addr = a;
    req_wdata = d;
    if (d0) req_valid0 = 1;
    else req_valid = 1;
    e = '{rdata: er, err: ee, lat: lat, t0: cyc};
    if (chk && d0) exp0.push_back(e);
    else if (chk) expq.push_back(e);
    @(negedge clk);
    req_valid = 0;
    req_valid0 = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && (expq.size() > 0 || exp0.size() > 0); i++) @(negedge clk);
    if (expq.size() > 0 || exp0.size() > 0) begin
      check("resp_timeout", 1, 0);
      expq.delete();
      exp0.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_bus", {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, 0);
    check("rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
    rst_n = 1;
    @(negedge clk);
    bq.push_back({1'b1, 32'h100, 4'b1111, 32'hDEADBEEF});
    issue(0, 1, 0, MEM_BS_WORD, 32'h100, 32'hDEADBEEF, 0, 0, 2);
    drain();
    bq.push_back({1'b1, 32'h100, 4'b1000, 32'hA5000000});
    issue(0, 1, 0, MEM_BS_BYTE, 32'h103, 32'h000000A5, 0, 0, 2);
    drain();
    bq.push_back({1'b0, 32'h100, 4'b1000, 32'h0});
    rq.push_back(32'h80000000);
    issue(0, 0, 1, MEM_BS_BYTE, 32'h103, 0, 32'hFFFFFF80, 0, 3);
    drain();
    bq.push_back({1'b0, 32'h100, 4'b1000, 32'h0});
    rq.push_back(32'h80000000);
    issue(0, 0, 0, MEM_BS_BYTE, 32'h103, 0, 32'h00000080, 0, 3);
    drain();
    for (int s = 0; s < 2; s++) begin
      bq.push_back({1'b0, 32'h100, 4'b1000, 32'h0});
      bq.push_back({1'b0, 32'h104, 4'b0001, 32'h0});
      rq.push_back(32'h11223344);
      rq.push_back(32'h55667788);
      issue(0, 0, s[0], MEM_BS_HALF, 32'h103, 0, s == 0 ? 32'h00008811 : 32'hFFFF8811, 0, 5);
      drain();
    end
    bq.push_back({1'b0, 32'h200, 4'b1100, 32'h0});
    rq.push_back(32'h80017777);
    issue(0, 0, 1, MEM_BS_HALF, 32'h202, 0, 32'hFFFF8001, 0, 3);
    drain();
    bq.push_back({1'b1, 32'h100, 4'b1100, 32'h56780000});
    bq.push_back({1'b1, 32'h104, 4'b0011, 32'h00001234});
    issue(0, 1, 0, MEM_BS_WORD, 32'h102, 32'h12345678, 0, 0, 3);
    drain();
    bq.push_back({1'b1, 32'hFFFFFFFC, 4'b1000, 32'hEF000000});
    bq.push_back({1'b1, 32'h00000000, 4'b0001, 32'h000000BE});
    issue(0, 1, 0, MEM_BS_HALF, 32'hFFFFFFFF, 32'hFFFFBEEF, 0, 0, 3);
    drain();
    issue(0, 0, 1, MEM_BS_NONE, 32'h100, 32'h1, 0, 1, 1);
    drain();
    issue(1, 0, 1, MEM_BS_HALF, 32'h103, 0, 0, 1, 1);
    drain();
    issue(1, 1, 0, MEM_BS_NONE, 32'h10, 32'h55, 0, 1, 1);
    drain();
    gnt_dly = 5;
    rv_dly = 3;
    unstable = 0;
    bq.push_back({1'b0, 32'h200, 4'b1111, 32'h0});
    rq.push_back(32'hCAFEF00D);
    issue(0, 0, 0, MEM_BS_WORD, 32'h200, 0, 32'hCAFEF00D, 0, 10);
    drain();
    check("ready_after_resp", req_ready, 1);
    gnt_dly = 3;
    bq.push_back({1'b1, 32'h200, 4'b0110, 32'h00123400});
    issue(0, 1, 0, MEM_BS_HALF, 32'h201, 32'hFFFF1234, 0, 0, 5);
    drain();
    check("hold_stable", unstable, 0);
    gnt_dly = 0;
    rv_dly = 6;
    bq.push_back({1'b0, 32'h400, 4'b1111, 32'h0});
    rq.push_back(32'h5555AAAA);
    issue(0, 0, 0, MEM_BS_WORD, 32'h400, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    check("mid_rst_bus_req", bus_req, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_resp", resp_valid, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    check("stray_rvalid_sent", rq.size(), 0);
    rv_dly = 1;
    bq.push_back({1'b1, 32'h300, 4'b1111, 32'h01020304});
    issue(0, 1, 0, MEM_BS_WORD, 32'h300, 32'h01020304, 0, 0, 2);
    drain();
    bq.push_back({1'b0, 32'h300, 4'b1111, 32'h0});
    rq.push_back(32'h01020304);
    issue(0, 0, 1, MEM_BS_WORD, 32'h300, 0, 32'h01020304, 0, 3);
    drain();
    check("beats_left", bq.size(), 0);
    check("dut0_no_bus", bus0_seen, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
